// File: rtl/hams_lane_fifo.sv
// hams_lane_fifo: multi-lane circular-buffer FIFO with occupancy status, sticky errors and FWFT/registered read modes
module hams_lane_fifo #(
    parameter int NUM_LANES    = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 8,
    parameter int AFULL_THRESH = FIFO_DEPTH - 2,
    parameter int FWFT         = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    push,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]         push_data,
    input  logic                                    pop,
    output logic [NUM_LANES*DATA_WIDTH-1:0]         pop_data,
    output logic                                    pop_valid,
    output logic                                    empty,
    output logic                                    full,
    output logic                                    almost_full,
    output logic [$clog2(FIFO_DEPTH):0]             entries,
    output logic                                    overflow,
    output logic                                    underflow,
    input  logic                                    clear_err
);
    localparam int W  = NUM_LANES * DATA_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AFULL_THRESH);

    logic [W-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d, ovf_q, ovf_d, udf_q, udf_d;
    logic          pop_ok, push_ok;

    // Accept decisions, pointer/occupancy next state and sticky error update (set beats clear)
    always_comb begin
        pop_ok   = pop && (count_q != '0);
        push_ok  = push && ((count_q != DEPTH_C) || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = (push_ok && !pop_ok) ? count_q + CW'(1) :
                   (pop_ok && !push_ok) ? count_q - CW'(1) : count_q;
        rdata_d  = pop_ok ? mem_q[rd_ptr_q] : rdata_q;
        rvalid_d = pop_ok;
        ovf_d    = (push && !push_ok) || (ovf_q && !clear_err);
        udf_d    = (pop && !pop_ok) || (udf_q && !clear_err);
    end

    // Control and read-register state; reset overrides every request
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is not reset; contents are only reachable through the pointers
    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    // Status decoded from registered occupancy; read path chosen by mode
    always_comb begin
        empty       = (count_q == '0);
        full        = (count_q == DEPTH_C);
        almost_full = (count_q >= AF_C);
        entries     = count_q;
        overflow    = ovf_q;
        underflow   = udf_q;
        pop_valid   = (FWFT != 0) ? !empty : rvalid_q;
        pop_data    = (FWFT != 0) ? (empty ? '0 : mem_q[rd_ptr_q]) : rdata_q;
    end
endmodule

// File: tb/tb_hams_lane_fifo.sv
// tb_hams_lane_fifo: table-driven checks of the FWFT instance plus hand sequences for registered-read and reset corners
module tb_hams_lane_fifo;
    logic         clk = 1'b0;
    logic         rst, push, pop, clear_err;
    logic [127:0] push_data;
    logic [127:0] pd1, pd0;
    logic         pv1, pv0, emp1, emp0, ful1, ful0, af1, af0, ovf1, ovf0, udf1, udf0;
    logic [3:0]   ent1, ent0;
    int           checks = 0;
    int           failures = 0;

    typedef struct {
        logic         push, pop, clr;
        logic [127:0] din;
        int           ent;
        logic         emp, ful, af, ovf, udf, pv;
        logic [127:0] pd;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    hams_lane_fifo #(.NUM_LANES(4), .DATA_WIDTH(32), .FIFO_DEPTH(8), .AFULL_THRESH(6), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
        .pop_data(pd1), .pop_valid(pv1), .empty(emp1), .full(ful1), .almost_full(af1),
        .entries(ent1), .overflow(ovf1), .underflow(udf1), .clear_err(clear_err)
    );

    hams_lane_fifo #(.NUM_LANES(4), .DATA_WIDTH(32), .FIFO_DEPTH(8), .AFULL_THRESH(6), .FWFT(0)) u_reg (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
        .pop_data(pd0), .pop_valid(pv0), .empty(emp0), .full(ful0), .almost_full(af0),
        .entries(ent0), .overflow(ovf0), .underflow(udf0), .clear_err(clear_err)
    );

    function automatic logic [127:0] e(int k);
        return {32'(k + 3), 32'(k + 2), 32'(k + 1), 32'(k)};
    endfunction

    function automatic void add(logic p, logic q, logic c, logic [127:0] d, int n,
                                logic em, logic fu, logic a, logic ov, logic un, logic v, logic [127:0] h);
        vec_t t;
        t.push = p; t.pop = q; t.clr = c; t.din = d; t.ent = n;
        t.emp = em; t.ful = fu; t.af = a; t.ovf = ov; t.udf = un; t.pv = v; t.pd = h;
        vecs.push_back(t);
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic step(logic p, logic q, logic c, logic [127:0] d);
        push = p; pop = q; clear_err = c; push_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b1, 128'h1234);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; clear_err = 1'b0; push_data = '0;
        @(posedge clk);
        #1;
        do_reset();
        chk("rst_entries", 128'(ent1), 128'd0);
        chk("rst_empty", 128'(emp1), 128'd1);
        chk("rst_full", 128'(ful1), 128'd0);
        chk("rst_af", 128'(af1), 128'd0);
        chk("rst_ovf", 128'(ovf1), 128'd0);
        chk("rst_udf", 128'(udf1), 128'd0);
        chk("rst_pv", 128'(pv1), 128'd0);
        chk("rst_pd", pd1, 128'd0);
        chk("rst_pv0", 128'(pv0), 128'd0);
        chk("rst_pd0", pd0, 128'd0);

        for (int i = 1; i <= 8; i++)
            add(1, 0, 0, e(4 * (i - 1)), i, 0, i == 8, i >= 6, 0, 0, 1, e(0));
        add(1, 0, 0, 128'hDEAD, 8, 0, 1, 1, 1, 0, 1, e(0));
        add(0, 0, 1, 128'h0, 8, 0, 1, 1, 0, 0, 1, e(0));
        add(1, 1, 0, 128'h99, 8, 0, 1, 1, 0, 0, 1, e(4));
        for (int j = 1; j <= 8; j++)
            add(0, 1, 0, 128'h0, 8 - j, j == 8, 0, (8 - j) >= 6, 0, 0, j != 8,
                j <= 6 ? e(4 + 4 * j) : (j == 7 ? 128'h99 : 128'h0));
        add(1, 1, 0, 128'h55, 1, 0, 0, 0, 0, 1, 1, 128'h55);
        add(0, 1, 1, 128'h0, 0, 1, 0, 0, 0, 0, 0, 128'h0);
        add(0, 1, 0, 128'h0, 0, 1, 0, 0, 0, 1, 0, 128'h0);
        add(0, 1, 1, 128'h0, 0, 1, 0, 0, 0, 1, 0, 128'h0);
        add(0, 0, 1, 128'h0, 0, 1, 0, 0, 0, 0, 0, 128'h0);

        foreach (vecs[i]) begin
            step(vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].din);
            chk($sformatf("v%0d_entries", i), 128'(ent1), 128'(vecs[i].ent));
            chk($sformatf("v%0d_empty", i), 128'(emp1), 128'(vecs[i].emp));
            chk($sformatf("v%0d_full", i), 128'(ful1), 128'(vecs[i].ful));
            chk($sformatf("v%0d_af", i), 128'(af1), 128'(vecs[i].af));
            chk($sformatf("v%0d_ovf", i), 128'(ovf1), 128'(vecs[i].ovf));
            chk($sformatf("v%0d_udf", i), 128'(udf1), 128'(vecs[i].udf));
            chk($sformatf("v%0d_pv", i), 128'(pv1), 128'(vecs[i].pv));
            chk($sformatf("v%0d_pd", i), pd1, vecs[i].pd);
            chk($sformatf("v%0d_entries0", i), 128'(ent0), 128'(vecs[i].ent));
        end

        do_reset();
        step(1, 0, 0, 128'hA);
        step(1, 0, 0, 128'hB);
        step(0, 1, 0, 128'h0);
        chk("reg_pop_pv", 128'(pv0), 128'd1);
        chk("reg_pop_pd", pd0, 128'hA);
        chk("fwft_head_b", pd1, 128'hB);
        step(0, 0, 0, 128'h0);
        chk("reg_idle1_pv", 128'(pv0), 128'd0);
        chk("reg_idle1_pd", pd0, 128'hA);
        step(0, 0, 0, 128'h0);
        chk("reg_idle2_pd", pd0, 128'hA);
        chk("reg_idle2_entries", 128'(ent0), 128'd1);

        do_reset();
        for (int k = 0; k < 5; k++) step(1, 0, 0, e(4 * k));
        chk("mid_entries5", 128'(ent0), 128'd5);
        step(0, 1, 0, 128'h0);
        chk("mid_pop_pv", 128'(pv0), 128'd1);
        chk("mid_pop_pd", pd0, e(0));
        rst = 1'b1;
        step(1, 1, 1, 128'hFF);
        rst = 1'b0;
        chk("mid_rst_entries", 128'(ent0), 128'd0);
        chk("mid_rst_empty", 128'(emp0), 128'd1);
        chk("mid_rst_pv", 128'(pv0), 128'd0);
        chk("mid_rst_pd", pd0, 128'd0);
        chk("mid_rst_entries1", 128'(ent1), 128'd0);
        step(0, 0, 0, 128'h0);
        chk("mid_after_pv", 128'(pv0), 128'd0);
        chk("mid_after_empty", 128'(emp0), 128'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
